// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: default vectors, sizing defaults and address helpers.
package fetch_unit_pkg;

  localparam int unsigned FETCH_XLEN_DEFAULT      = 32;
  localparam int unsigned FETCH_DEPTH_DEFAULT     = 2;
  localparam int unsigned FETCH_INSN_BYTES        = 4;
  localparam logic [31:0] FETCH_RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] FETCH_TRAP_VEC_DEFAULT  = 32'h0000_0004;

  // A fetch target must be word aligned for RV32I without the C extension.
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with clear, push, pop, occupancy count and combinational head.
module fetch_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_idx;
  logic             wr_en;
  logic             do_pop;
  logic             do_push;

  // Clear takes priority; a push in the clear cycle lands in slot 0 of the emptied FIFO.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    wr_idx   = wr_ptr_q;
    wr_en    = do_push;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_idx   = '0;
      wr_en    = push_i;
      wr_ptr_d = push_i ? PTR_W'(1) : '0;
      cnt_d    = push_i ? CNT_W'(1) : '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset: the head is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Prefetching instruction-fetch front end: issues word fetches to the MMU, squashes stale
// responses after redirects/traps and hands instructions to FD through a valid/ready FIFO.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned      XLEN      = FETCH_XLEN_DEFAULT,
  parameter int unsigned      DEPTH     = FETCH_DEPTH_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(FETCH_RESET_VEC_DEFAULT),
  parameter logic [XLEN-1:0]  TRAP_VEC  = XLEN'(FETCH_TRAP_VEC_DEFAULT)
) (
  input  logic            clk,
  input  logic            resetb,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_gnt,
  input  logic            im_rvalid,
  input  logic [XLEN-1:0] im_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  output logic            fd_valid,
  input  logic            fd_ready,
  output logic [XLEN-1:0] fd_inst,
  output logic [XLEN-1:0] fd_pc,
  output logic            fd_misaligned
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W   = CNT_W + 1;
  localparam int unsigned DROP_W  = CNT_W + 1;
  localparam int unsigned ENTRY_W = 2 * XLEN + 1;

  logic              run_q;
  logic              halt_q, halt_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic               fifo_clear, fifo_push, fifo_pop, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_head;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [OCC_W-1:0]   occ;

  logic            gnt_acc, rsp_keep, rsp_drop, redirect, tgt_mis;
  logic [XLEN-1:0] target;

  // Issue capacity comes from registered counts only, so a pop never frees a slot the same cycle.
  assign occ     = OCC_W'(fifo_cnt) + OCC_W'(out_cnt_q);
  assign im_req  = run_q && !halt_q && (occ < OCC_W'(DEPTH));
  assign im_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    halt_d     = halt_q;
    fifo_clear = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;

    gnt_acc  = im_req && im_gnt;
    rsp_drop = im_rvalid && (drop_cnt_q != '0);
    rsp_keep = im_rvalid && (drop_cnt_q == '0);
    redirect = trap_valid || redirect_valid;
    target   = trap_valid ? TRAP_VEC : redirect_pc;
    tgt_mis  = addr_misaligned(target[1:0]);
    fifo_wdata = {resp_pc_q, im_rdata, 1'b0};

    if (redirect) begin
      // Everything in flight, including this cycle's grant, is now stale; this cycle's response goes too.
      drop_cnt_d = drop_cnt_q + DROP_W'(out_cnt_q) + DROP_W'(gnt_acc) - DROP_W'(im_rvalid);
      out_cnt_d  = '0;
      fetch_pc_d = target;
      resp_pc_d  = target;
      halt_d     = tgt_mis;
      fifo_clear = 1'b1;
      fifo_push  = tgt_mis;
      fifo_wdata = {target, {XLEN{1'b0}}, 1'b1};
    end else begin
      if (gnt_acc) fetch_pc_d = fetch_pc_q + XLEN'(FETCH_INSN_BYTES);
      if (rsp_keep) resp_pc_d = resp_pc_q + XLEN'(FETCH_INSN_BYTES);
      out_cnt_d  = out_cnt_q + CNT_W'(gnt_acc) - CNT_W'(rsp_keep);
      drop_cnt_d = drop_cnt_q - DROP_W'(rsp_drop);
      fifo_push  = rsp_keep;
      fifo_pop   = !fifo_empty && fd_ready;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      run_q      <= 1'b0;
      halt_q     <= 1'b0;
      fetch_pc_q <= RESET_VEC;
      resp_pc_q  <= RESET_VEC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      run_q      <= 1'b1;
      halt_q     <= halt_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetb      (resetb),
    .clear_i     (fifo_clear),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt),
    .empty_o     (fifo_empty)
  );

  // Head fields are zeroed while empty so FD never sees stale storage.
  assign fd_valid      = !fifo_empty;
  assign fd_pc         = fd_valid ? fifo_head[ENTRY_W-1 -: XLEN] : '0;
  assign fd_inst       = fd_valid ? fifo_head[XLEN -: XLEN] : '0;
  assign fd_misaligned = fd_valid && fifo_head[0];

endmodule
